id_ex_alu_issue: RTL and testbench

Decode/issue stage register feeding the EX-stage ALU of the pipelined MIPS core. It takes the IF/ID instruction and register-file operands, decodes the ALU operation, builds both ALU operands with immediate extension and EX/MEM forwarding, and registers the result into the ID/EX boundary. It also detects load-use hazards and inserts bubbles, and honours downstream stall and branch flush.

---
 rtl/alu_pkg.sv | 58 +++++
 rtl/operand_fwd.sv | 25 ++
 rtl/id_ex_alu_issue.sv | 198 +++++++++++++++++++
 tb/tb_id_ex_alu_issue.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, MIPS opcode/funct constants and the ID/EX register
// layout (including its bubble value) for the decode/issue stage.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b010,
        ALU_AND  = 3'b011,
        ALU_OR   = 3'b100,
        ALU_SLL  = 3'b101,
        ALU_SLLV = 3'b110,
        ALU_SRAV = 3'b111
    } alu_sel_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;

    typedef struct packed {
        logic [31:0] alu_in1;
        logic [31:0] alu_in2;
        logic [31:0] store_data;
        alu_sel_e    sel;
        logic [4:0]  shamt;
        logic [4:0]  dest;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        valid;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '{
        alu_in1:    '0,
        alu_in2:    '0,
        store_data: '0,
        sel:        ALU_ADD,
        shamt:      '0,
        dest:       '0,
        regwrite:   1'b0,
        memread:    1'b0,
        memwrite:   1'b0,
        valid:      1'b0
    };

endpackage

// File: rtl/operand_fwd.sv
// Combinational operand forwarding mux: $0, then EX result, then MEM value,
// then register-file data.
module operand_fwd (
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_rf_data,
    input  logic        i_ex_en,
    input  logic [4:0]  i_ex_dest,
    input  logic [31:0] i_ex_result,
    input  logic        i_mem_en,
    input  logic [4:0]  i_mem_dest,
    input  logic [31:0] i_mem_value,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_rf_data;
        if (i_addr == 5'd0)
            o_data = '0;
        else if (i_ex_en && (i_ex_dest == i_addr))
            o_data = i_ex_result;
        else if (i_mem_en && (i_mem_dest == i_addr))
            o_data = i_mem_value;
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: decodes the ALU op, forwards and extends operands,
// detects load-use hazards and registers everything into the ID/EX boundary.
module id_ex_alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        InstrValid,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    input  logic [31:0] ExResult,
    input  logic        MemRegWrite,
    input  logic [4:0]  MemDest,
    input  logic [31:0] MemValue,
    input  logic        StallIn,
    input  logic        FlushIn,
    output logic [31:0] ALUIn1,
    output logic [31:0] ALUIn2,
    output logic [2:0]  ALUSel,
    output logic [4:0]  Shamt,
    output logic [4:0]  DestReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        ExValid,
    output logic [31:0] StoreData,
    output logic        StallOut,
    output logic        Illegal
);

    id_ex_t r_q;
    id_ex_t w_d;
    logic   r_illegal;

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_imm;

    assign w_op    = Instr[31:26];
    assign w_rs    = Instr[25:21];
    assign w_rt    = Instr[20:16];
    assign w_rd    = Instr[15:11];
    assign w_funct = Instr[5:0];

    alu_sel_e   w_sel;
    logic [4:0] w_dest, w_shamt;
    logic       w_regwrite, w_memread, w_memwrite;
    logic       w_use_imm, w_sign_ext, w_rt_src, w_var_shift, w_legal;

    always_comb begin
        w_sel       = ALU_ADD;
        w_dest      = '0;
        w_shamt     = '0;
        w_regwrite  = 1'b0;
        w_memread   = 1'b0;
        w_memwrite  = 1'b0;
        w_use_imm   = 1'b1;
        w_sign_ext  = 1'b1;
        w_rt_src    = 1'b0;
        w_var_shift = 1'b0;
        w_legal     = 1'b1;
        case (w_op)
            OP_RTYPE: begin
                w_use_imm  = 1'b0;
                w_rt_src   = 1'b1;
                w_dest     = w_rd;
                w_regwrite = 1'b1;
                case (w_funct)
                    FN_ADD, FN_ADDU: w_sel = ALU_ADD;
                    FN_SUB:          w_sel = ALU_SUB;
                    FN_AND:          w_sel = ALU_AND;
                    FN_OR:           w_sel = ALU_OR;
                    FN_SLL: begin
                        w_sel   = ALU_SLL;
                        w_shamt = Instr[10:6];
                    end
                    FN_SLLV: begin
                        w_sel       = ALU_SLLV;
                        w_var_shift = 1'b1;
                    end
                    FN_SRAV: begin
                        w_sel       = ALU_SRAV;
                        w_var_shift = 1'b1;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OP_ADDI: begin
                w_dest     = w_rt;
                w_regwrite = 1'b1;
            end
            OP_ANDI: begin
                w_sel      = ALU_AND;
                w_sign_ext = 1'b0;
                w_dest     = w_rt;
                w_regwrite = 1'b1;
            end
            OP_ORI: begin
                w_sel      = ALU_OR;
                w_sign_ext = 1'b0;
                w_dest     = w_rt;
                w_regwrite = 1'b1;
            end
            OP_LW: begin
                w_dest     = w_rt;
                w_regwrite = 1'b1;
                w_memread  = 1'b1;
            end
            OP_SW: begin
                w_memwrite = 1'b1;
                w_rt_src   = 1'b1;
            end
            OP_BEQ: begin
                w_sel     = ALU_SUB;
                w_use_imm = 1'b0;
                w_rt_src  = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_imm = w_sign_ext ? {{16{Instr[15]}}, Instr[15:0]} : {16'b0, Instr[15:0]};

    // A load in EX has no result yet, so it is excluded from EX forwarding.
    logic        w_ex_fwd_en;
    logic [31:0] w_rs_fwd, w_rt_fwd;

    assign w_ex_fwd_en = r_q.valid & r_q.regwrite & ~r_q.memread;

    operand_fwd u_fwd_rs (
        .i_addr      (w_rs),
        .i_rf_data   (RsData),
        .i_ex_en     (w_ex_fwd_en),
        .i_ex_dest   (r_q.dest),
        .i_ex_result (ExResult),
        .i_mem_en    (MemRegWrite),
        .i_mem_dest  (MemDest),
        .i_mem_value (MemValue),
        .o_data      (w_rs_fwd)
    );

    operand_fwd u_fwd_rt (
        .i_addr      (w_rt),
        .i_rf_data   (RtData),
        .i_ex_en     (w_ex_fwd_en),
        .i_ex_dest   (r_q.dest),
        .i_ex_result (ExResult),
        .i_mem_en    (MemRegWrite),
        .i_mem_dest  (MemDest),
        .i_mem_value (MemValue),
        .o_data      (w_rt_fwd)
    );

    logic w_load_use, w_take;

    assign w_load_use = r_q.valid & r_q.memread & (r_q.dest != 5'd0) &
                        ((r_q.dest == w_rs) | (w_rt_src & (r_q.dest == w_rt)));
    assign StallOut   = ~reset & ~StallIn & ~FlushIn & w_load_use;
    assign w_take     = InstrValid & ~FlushIn & ~w_load_use;

    always_comb begin
        w_d            = ID_EX_BUBBLE;
        w_d.alu_in1    = w_var_shift ? {27'b0, w_rs_fwd[4:0]} : w_rs_fwd;
        w_d.alu_in2    = w_use_imm ? w_imm : w_rt_fwd;
        w_d.store_data = w_rt_fwd;
        w_d.sel        = w_sel;
        w_d.shamt      = w_shamt;
        w_d.dest       = w_dest;
        w_d.regwrite   = w_regwrite;
        w_d.memread    = w_memread;
        w_d.memwrite   = w_memwrite;
        w_d.valid      = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q       <= ID_EX_BUBBLE;
            r_illegal <= 1'b0;
        end else if (!StallIn) begin
            r_q       <= (w_take && w_legal) ? w_d : ID_EX_BUBBLE;
            r_illegal <= w_take & ~w_legal;
        end
    end

    assign ALUIn1    = r_q.alu_in1;
    assign ALUIn2    = r_q.alu_in2;
    assign ALUSel    = r_q.sel;
    assign Shamt     = r_q.shamt;
    assign DestReg   = r_q.dest;
    assign RegWrite  = r_q.regwrite;
    assign MemRead   = r_q.memread;
    assign MemWrite  = r_q.memwrite;
    assign ExValid   = r_q.valid;
    assign StoreData = r_q.store_data;
    assign Illegal   = r_illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed bench for id_ex_alu_issue: each step queues the expected ID/EX
// contents, which are popped and compared one clock later.
module tb_id_ex_alu_issue;

    logic        clk = 1'b0;
    logic        reset, InstrValid, MemRegWrite, StallIn, FlushIn;
    logic [31:0] Instr, RsData, RtData, ExResult, MemValue;
    logic [4:0]  MemDest;
    logic [31:0] ALUIn1, ALUIn2, StoreData;
    logic [2:0]  ALUSel;
    logic [4:0]  Shamt, DestReg;
    logic        RegWrite, MemRead, MemWrite, ExValid, StallOut, Illegal;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_alu_issue dut (
        .clk(clk), .reset(reset), .Instr(Instr), .InstrValid(InstrValid),
        .RsData(RsData), .RtData(RtData), .ExResult(ExResult),
        .MemRegWrite(MemRegWrite), .MemDest(MemDest), .MemValue(MemValue),
        .StallIn(StallIn), .FlushIn(FlushIn),
        .ALUIn1(ALUIn1), .ALUIn2(ALUIn2), .ALUSel(ALUSel), .Shamt(Shamt),
        .DestReg(DestReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .ExValid(ExValid), .StoreData(StoreData),
        .StallOut(StallOut), .Illegal(Illegal)
    );

    typedef struct {
        logic [31:0] a1, a2, sd;
        logic [2:0]  sel;
        logic [4:0]  sh, dest;
        logic        rw, mr, mw, v, ill;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk(logic [31:0] a1, logic [31:0] a2, logic [2:0] sel,
                                logic [4:0] sh, logic [4:0] dest, logic rw, logic mr,
                                logic mw, logic v, logic [31:0] sd, logic ill);
        exp_t e;
        e.a1 = a1; e.a2 = a2; e.sel = sel; e.sh = sh; e.dest = dest;
        e.rw = rw; e.mr = mr; e.mw = mw; e.v = v; e.sd = sd; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t bubble(logic ill);
        return mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, ill);
    endfunction

    function automatic logic [31:0] rtype(int rs, int rt, int rd, int sh, logic [5:0] fn);
        logic [31:0] w;
        w = {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn};
        return w;
    endfunction

    function automatic logic [31:0] itype(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        logic [31:0] w;
        w = {op, rs[4:0], rt[4:0], imm};
        return w;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one cycle of inputs, checks StallOut now and the registered
    // outputs after the next rising edge.
    task automatic step(string name, logic rst, logic stall, logic flush,
                        logic [31:0] ins, logic vld, logic [31:0] rs, logic [31:0] rt,
                        logic [31:0] exr, logic mrw, logic [4:0] mdst, logic [31:0] mval,
                        logic exp_so, exp_t e);
        exp_t g;
        reset = rst; StallIn = stall; FlushIn = flush; Instr = ins; InstrValid = vld;
        RsData = rs; RtData = rt; ExResult = exr;
        MemRegWrite = mrw; MemDest = mdst; MemValue = mval;
        #1;
        chk({name, ".StallOut"}, {31'b0, StallOut}, {31'b0, exp_so});
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk({name, ".ALUIn1"},    ALUIn1,               g.a1);
        chk({name, ".ALUIn2"},    ALUIn2,               g.a2);
        chk({name, ".ALUSel"},    {29'b0, ALUSel},      {29'b0, g.sel});
        chk({name, ".Shamt"},     {27'b0, Shamt},       {27'b0, g.sh});
        chk({name, ".DestReg"},   {27'b0, DestReg},     {27'b0, g.dest});
        chk({name, ".RegWrite"},  {31'b0, RegWrite},    {31'b0, g.rw});
        chk({name, ".MemRead"},   {31'b0, MemRead},     {31'b0, g.mr});
        chk({name, ".MemWrite"},  {31'b0, MemWrite},    {31'b0, g.mw});
        chk({name, ".ExValid"},   {31'b0, ExValid},     {31'b0, g.v});
        chk({name, ".StoreData"}, StoreData,            g.sd);
        chk({name, ".Illegal"},   {31'b0, Illegal},     {31'b0, g.ill});
    endtask

    initial begin
        exp_t hold;

        step("reset", 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, bubble(0));

        step("add", 0, 0, 0, rtype(1, 2, 3, 0, 6'h20), 1, 5, 7, 0, 0, 0, 0,
             0, mk(5, 7, 3'b000, 0, 3, 1, 0, 0, 1, 7, 0));
        step("addi_neg", 0, 0, 0, itype(6'h08, 0, 4, 16'hFFFF), 1, 32'hDEAD, 32'h11, 0, 0, 0, 0,
             0, mk(0, 32'hFFFFFFFF, 3'b000, 0, 4, 1, 0, 0, 1, 32'h11, 0));
        step("ori_zext", 0, 0, 0, itype(6'h0D, 0, 5, 16'hFFFF), 1, 32'hBEEF, 32'h22, 0, 0, 0, 0,
             0, mk(0, 32'h0000FFFF, 3'b100, 0, 5, 1, 0, 0, 1, 32'h22, 0));
        step("lw", 0, 0, 0, itype(6'h23, 1, 2, 16'h0000), 1, 32'h100, 32'h33, 0, 0, 0, 0,
             0, mk(32'h100, 0, 3'b000, 0, 2, 1, 1, 0, 1, 32'h33, 0));
        step("loaduse", 0, 0, 0, rtype(2, 2, 3, 0, 6'h20), 1, 32'h99, 32'h99, 0, 0, 0, 0,
             1, bubble(0));
        step("after_lu", 0, 0, 0, rtype(2, 2, 3, 0, 6'h20), 1, 32'h99, 32'h99, 0, 1, 2, 32'h1234,
             0, mk(32'h1234, 32'h1234, 3'b000, 0, 3, 1, 0, 0, 1, 32'h1234, 0));
        step("sllv_exfwd", 0, 0, 0, rtype(3, 4, 6, 0, 6'h04), 1, 32'h77, 32'h40, 32'hFFFFFFE9, 1, 3, 32'h55,
             0, mk(9, 32'h40, 3'b110, 0, 6, 1, 0, 0, 1, 32'h40, 0));
        step("lw2", 0, 0, 0, itype(6'h23, 0, 7, 16'h0004), 1, 32'h66, 32'h44, 0, 0, 0, 0,
             0, mk(0, 4, 3'b000, 0, 7, 1, 1, 0, 1, 32'h44, 0));
        step("flush_lu", 0, 0, 1, rtype(7, 0, 8, 0, 6'h20), 1, 1, 2, 0, 0, 0, 0,
             0, bubble(0));
        hold = mk(1, 2, 3'b000, 0, 9, 1, 0, 0, 1, 2, 0);
        step("pre_stall", 0, 0, 0, rtype(1, 2, 9, 0, 6'h20), 1, 1, 2, 0, 0, 0, 0, 0, hold);
        for (int i = 0; i < 3; i++)
            step("stall", 0, 1, 0, rtype(4, 5, 12, 0, 6'h22), 1, 32'hAA + i, 32'hBB, 0, 0, 0, 0, 0, hold);
        step("illegal", 0, 0, 0, rtype(1, 2, 3, 0, 6'h2A), 1, 3, 4, 0, 0, 0, 0, 0, bubble(1));
        step("post_ill", 0, 0, 0, rtype(1, 2, 10, 0, 6'h20), 1, 3, 4, 0, 0, 0, 0,
             0, mk(3, 4, 3'b000, 0, 10, 1, 0, 0, 1, 4, 0));
        step("beq", 0, 0, 0, itype(6'h04, 1, 2, 16'h0008), 1, 32'hA, 32'hB, 0, 0, 0, 0,
             0, mk(32'hA, 32'hB, 3'b010, 0, 0, 0, 0, 0, 1, 32'hB, 0));
        step("sw", 0, 0, 0, itype(6'h2B, 1, 5, 16'hFFF8), 1, 32'h200, 32'h5555, 0, 0, 0, 0,
             0, mk(32'h200, 32'hFFFFFFF8, 3'b000, 0, 0, 0, 0, 1, 1, 32'h5555, 0));
        step("sll", 0, 0, 0, rtype(0, 2, 11, 4, 6'h00), 1, 32'h8, 32'h3, 0, 0, 0, 0,
             0, mk(0, 3, 3'b101, 4, 11, 1, 0, 0, 1, 3, 0));
        step("invalid", 0, 0, 0, rtype(1, 2, 3, 0, 6'h20), 0, 1, 2, 0, 0, 0, 0, 0, bubble(0));
        step("pre_rst", 0, 0, 0, rtype(1, 2, 12, 0, 6'h20), 1, 32'h77, 32'h88, 0, 0, 0, 0,
             0, mk(32'h77, 32'h88, 3'b000, 0, 12, 1, 0, 0, 1, 32'h88, 0));
        step("rst_stall", 1, 1, 0, rtype(1, 2, 13, 0, 6'h20), 1, 1, 2, 0, 0, 0, 0, 0, bubble(0));
        step("post_rst", 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, bubble(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
